// File: rtl/lmem_arbiter.sv
// Round-robin arbiter sharing the single layer-memory port among NREQ requesters.
// Optional locked-run arbitration is enabled by defining LMEM_ARB_LOCK_EN.
module lmem_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 12,
  parameter int DW   = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [3*NREQ-1:0]    req_sel,
  input  logic [AW*NREQ-1:0]   req_addr,
  input  logic [DW*NREQ-1:0]   req_wdata,
`ifdef LMEM_ARB_LOCK_EN
  input  logic [NREQ-1:0]      req_lock,
`endif
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW-1:0]        rdata,
  output logic                 busy,
  output logic                 cwr,
  output logic                 crd,
  output logic [2:0]           csel,
  output logic [AW-1:0]        caddr_wr,
  output logic [AW-1:0]        caddr_rd,
  output logic [DW-1:0]        cdata_wr,
  input  logic [DW-1:0]        cdata_rd
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] rr_ptr_nxt;
  logic          gnt_any;
  logic [IW-1:0] gnt_idx;
  logic          lock_hit;

  // Return pipeline carries only who asked and whether a read is in flight.
  logic          p1_valid;
  logic [IW-1:0] p1_idx;

`ifdef LMEM_ARB_LOCK_EN
  logic          last_valid;
  logic [IW-1:0] last_idx;
  logic [4:0]    run_cnt;

  // A locked run keeps the previous winner for at most 16 consecutive grants.
  assign lock_hit = last_valid && req_lock[last_idx] && req[last_idx] && (run_cnt < 5'd16);
`else
  assign lock_hit = 1'b0;
`endif

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    gnt_any    = 1'b0;
    gnt_idx    = '0;
    gnt        = '0;
    rr_ptr_nxt = rr_ptr;
    // Walk from farthest to nearest so the candidate closest to rr_ptr wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      logic [IW-1:0] cand;
      cand = IW'((int'(rr_ptr) + k) % NREQ);
      if (req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
`ifdef LMEM_ARB_LOCK_EN
    if (lock_hit) begin
      gnt_any = 1'b1;
      gnt_idx = last_idx;
    end
`endif
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
      if (!lock_hit) begin
        rr_ptr_nxt = (gnt_idx == IW'(NREQ - 1)) ? '0 : IW'(gnt_idx + 1'b1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      cwr      <= 1'b0;
      crd      <= 1'b0;
      csel     <= '0;
      caddr_wr <= '0;
      caddr_rd <= '0;
      cdata_wr <= '0;
      p1_valid <= 1'b0;
      p1_idx   <= '0;
      rvalid   <= '0;
      busy     <= 1'b0;
    end else begin
      rr_ptr <= rr_ptr_nxt;
      cwr    <= gnt_any &&  req_we[gnt_idx];
      crd    <= gnt_any && !req_we[gnt_idx];
      if (gnt_any) begin
        csel <= req_sel[3*gnt_idx +: 3];
        if (req_we[gnt_idx]) begin
          caddr_wr <= req_addr[AW*gnt_idx +: AW];
          cdata_wr <= req_wdata[DW*gnt_idx +: DW];
        end else begin
          caddr_rd <= req_addr[AW*gnt_idx +: AW];
        end
      end
      p1_valid <= gnt_any && !req_we[gnt_idx];
      p1_idx   <= gnt_idx;
      rvalid   <= '0;
      if (p1_valid) begin
        rvalid[p1_idx] <= 1'b1;
      end
      // cwr/crd mark a command in its T+1 cycle, so this covers T+1 and T+2.
      busy <= gnt_any || cwr || crd;
    end
  end

`ifdef LMEM_ARB_LOCK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_valid <= 1'b0;
      last_idx   <= '0;
      run_cnt    <= '0;
    end else begin
      last_valid <= gnt_any;
      last_idx   <= gnt_idx;
      if (gnt_any) begin
        run_cnt <= lock_hit ? run_cnt + 5'd1 : 5'd1;
      end
    end
  end
`endif

  assign rdata = cdata_rd;

endmodule

// File: doc/lmem_arbiter.md
Name: lmem_arbiter

Overview:
- Round-robin arbiter that shares the single layer-memory port (csel/crd/cwr/caddr_rd/caddr_wr/cdata_wr/cdata_rd) among NREQ requesters.
- Typical requesters: conv engine (L0 writes), max-pool engine (L0 reads, L1 writes) and host readback.
- Issues at most one memory command per cycle, drives memory-side outputs from registers, and routes read data back to the originating requester with fixed latency.

Parameters:
- NREQ, 3, number of requesters (2..8).
- AW, 12, memory address width.
- DW, 20, memory data width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- req  in  NREQ  per-requester command request; must hold until granted.
- req_we  in  NREQ  1 = write, 0 = read.
- req_sel  in  3*NREQ  csel value per requester; slice i is [3i+2:3i].
- req_addr  in  AW*NREQ  address per requester; slice i is [AW*i+AW-1:AW*i].
- req_wdata  in  DW*NREQ  write data per requester.
- gnt  out  NREQ  one-hot combinational grant; a command is accepted when req[i]&gnt[i].
- rvalid  out  NREQ  one-hot, registered; read data valid for requester i.
- rdata  out  DW  read data, equal to cdata_rd.
- busy  out  1  registered; high while any command is in the 2-cycle pipeline.
- cwr  out  1  memory write strobe.
- crd  out  1  memory read strobe.
- csel  out  3  memory select.
- caddr_wr  out  AW  write address.
- caddr_rd  out  AW  read address.
- cdata_wr  out  DW  write data.
- cdata_rd  in  DW  memory read data, valid the cycle after crd.

Behaviour:
- Reset (asynchronous):
  - gnt is 0 (no req), rvalid is 0 and busy is 0.
  - cwr, crd, csel, caddr_wr, caddr_rd and cdata_wr are all 0.
  - rr_ptr is 0.
  - In-flight reads are discarded; no rvalid ever fires for them.
- Arbitration (combinational, cycle T):
  - Scan req starting at index rr_ptr, wrapping modulo NREQ.
  - The first asserted bit wins; gnt is one-hot or all zero.
  - On a grant to index i, rr_ptr becomes (i+1) mod NREQ at the next edge.
  - With no grant, rr_ptr holds.
- Command stage (registered, cycle T+1):
  - Write grant: cwr=1, crd=0; caddr_wr, cdata_wr and csel are loaded from slice i; caddr_rd holds.
  - Read grant: crd=1, cwr=0; caddr_rd and csel are loaded from slice i; caddr_wr and cdata_wr hold.
  - No grant: cwr=0 and crd=0; address, data and csel registers hold their last values.
  - cwr and crd are never both 1.
- Return stage (cycle T+2):
  - rvalid[i]=1 for exactly one cycle, only for reads.
  - rdata=cdata_rd in that cycle.
  - The pipeline register tracks only the requester index plus a valid bit.
- Throughput and ordering:
  - One accepted command per cycle, including back-to-back reads from different requesters.
  - Returns arrive in issue order.
- busy is high at T+1 and T+2 of any accepted command.
- Fairness: a requester holding req is granted within NREQ cycles.
- req_sel of 0 is forwarded unchanged; this block does no validity checking.
- Deasserting req without a grant is legal; that command is simply dropped.
- Reset mid-stream: all outputs return to reset values immediately; nothing replays after release.

Optional Feature:
- Macro LMEM_ARB_LOCK_EN. When defined:
  - Adds input req_lock[NREQ].
  - If the requester granted at T has req_lock=1 and req=1 at T+1, it is granted again at T+1 regardless of rr_ptr.
  - rr_ptr does not advance during a locked run.
  - A run is capped at 16 consecutive grants, after which rr_ptr = i+1 and normal scanning resumes for at least one cycle.
  - Intended for 4-read max-pool windows.
- When undefined: the req_lock port is absent and arbitration is pure round-robin.
  - The fairness bound becomes NREQ cycles; with the feature it is NREQ*16.

Test Plan:
- Reset, then req=3'b001 read, addr 12'h041, sel 1 → gnt=001 at T; crd=1, caddr_rd=041, csel=1 at T+1; rvalid=001 at T+2 with rdata equal to the memory model's word at 041.
- req=3'b111 held with all reads for 6 cycles, rr_ptr=0 → grants 001,010,100,001,010,100; crd high continuously; rvalid follows the same order 2 cycles later.
- Requester 1 write (sel 3, addr 12'h3FF, data 20'h0A5A5) while requester 2 reads → write issued first (cwr=1, caddr_wr=3FF, cdata_wr=0A5A5, csel=3), read next cycle; cwr and crd never both high.
- Reset asserted one cycle after a read grant → rvalid stays 0; memory outputs are 0 immediately; the first grant after release goes to index 0.
- LMEM_ARB_LOCK_EN: requester 1 locked with 20 reads, requester 0 requesting → requester 1 gets 16 consecutive grants, then requester 0 gets 1, then requester 1 resumes.
